fetch_seq: RTL

Instruction fetch sequencer for the ECU front end. It reads opcode and operand bytes one at a time from the byte-wide program memory and derives the instruction length from the opcode. It packs the bytes into a 32-bit word and writes the word into the instruction register (`ir`) using that register's `raw`/`len`/`we` write interface. It is the producer side of the `ir` load interface.

---
 rtl/ecu_pkg.sv | 30 +++
 rtl/fetch_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ecu_pkg.sv
// ecu_pkg: definitions shared by the ECU front end (fetch sequencer and ir).
//   fetch_state_e : fetch sequencer states
//   len_of()      : operand-byte count encoded in an opcode
//   LANE_*        : byte lanes of the packed 32-bit instruction word
//   lane_lsb()    : bit offset of a byte lane inside the packed word
package ecu_pkg;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_OPND  = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

  localparam int BYTE_W = 8;

  localparam logic [1:0] LANE_OP = 2'd0;
  localparam logic [1:0] LANE_D1 = 2'd1;
  localparam logic [1:0] LANE_D2 = 2'd2;
  localparam logic [1:0] LANE_D3 = 2'd3;

  // Operand count lives in the two top opcode bits.
  function automatic logic [1:0] len_of(input logic [7:0] opcode);
    return opcode[7:6];
  endfunction

  function automatic int lane_lsb(input logic [1:0] lane);
    return int'(lane) * BYTE_W;
  endfunction

endpackage

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer.
// Reads the opcode and its operand bytes one at a time from byte-wide program
// memory, packs them into a 32-bit word and presents it to the instruction
// register through the raw/len/we write interface.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   mem_req, mem_addr   byte read request / address (addr held until acked)
//   mem_data, mem_ack   read data / completion (a byte moves when req & ack)
//   pc_load, pc_in      fetch redirect and its target
//   ir_ready            downstream accepts an instruction this cycle
//   raw, len, insn_pc   packed instruction, operand count, opcode address
//   we                  one-cycle write strobe into ir
//
// Handshakes: a memory byte transfers on a rising edge with mem_req and
// mem_ack both high; an instruction transfers on a rising edge with we high,
// and we is only raised while ir_ready is high.
module fetch_seq
  import ecu_pkg::*;
#(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  input  logic          mem_ack,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_in,
  input  logic          ir_ready,
  output logic [31:0]   raw,
  output logic [1:0]    len,
  output logic          we,
  output logic [AW-1:0] insn_pc
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   raw_q, raw_d;
  logic [1:0]    len_q, len_d;
  logic [AW-1:0] insn_pc_q, insn_pc_d;
  logic [1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_OP;
      pc_q      <= RESET_PC;
      raw_q     <= '0;
      len_q     <= '0;
      insn_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      raw_q     <= raw_d;
      len_q     <= len_d;
      insn_pc_q <= insn_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    raw_d     = raw_q;
    len_d     = len_q;
    insn_pc_d = insn_pc_q;
    cnt_d     = cnt_q;
    mem_req   = 1'b0;
    we        = 1'b0;

    if (!rst) begin
      // Outputs stay quiet while reset is asserted; the flops reset on the edge.
    end else if (pc_load) begin
      // Redirect wins over everything, including an ack landing this cycle.
      pc_d    = pc_in;
      state_d = S_OP;
      raw_d   = '0;
      len_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_OP: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            raw_d     = {24'h0, mem_data};
            len_d     = len_of(mem_data);
            insn_pc_d = pc_q;
            pc_d      = pc_q + AW'(1);
            if (len_of(mem_data) == 2'd0) begin
              state_d = S_ISSUE;
            end else begin
              state_d = S_OPND;
              cnt_d   = LANE_D1;
            end
          end
        end
        S_OPND: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            // cnt doubles as the byte lane the operand lands in.
            raw_d[lane_lsb(cnt_q) +: BYTE_W] = mem_data;
            pc_d = pc_q + AW'(1);
            if (cnt_q == len_q) begin
              state_d = S_ISSUE;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        S_ISSUE: begin
          we = ir_ready;
          if (ir_ready) begin
            state_d = S_OP;
          end
        end
        default: begin
          state_d = S_OP;
        end
      endcase
    end
  end

  assign mem_addr = rst ? pc_q : RESET_PC;
  assign raw      = raw_q;
  assign len      = len_q;
  assign insn_pc  = insn_pc_q;

endmodule
